score_meter: RTL and testbench
==============================

Name: score_meter

Overview:
- Parametrised successor to the distance meter. Converts per-frame scroll speed into a saturating BCD score of NUM_DIGITS digits, with no divide or modulo in the datapath.
- Flashes the score for a fixed number of on/off cycles at every achievement boundary, showing the latched achievement value during the flash.
- Tracks a high score across runs and exposes it as BCD digits.
- Sits between the game FSM (speed, restart, game_over, frame tick) and the sprite renderer (digit indices, paint enables).

Parameters:
- NUM_DIGITS, 5: number of BCD digits; score saturates at all-9s.
- SPEED_W, 15: width of the speed input.
- COEFFICIENT, 40960: accumulated speed per score unit (40 * SPEED_SCALE). Must be greater than the maximum speed value.
- ACH_DIGITS, 2: achievement every 10**ACH_DIGITS units. Must be in 1..NUM_DIGITS-1.
- FLASH_DURATION, 15: update ticks per half-period of the flash.
- FLASH_ITERATIONS, 3: number of off/on pairs per achievement. Must be at least 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- update  in  1  one-cycle frame tick
- speed  in  SPEED_W  current scroll speed; 0 means halted
- restart  in  1  one-cycle pulse: new run begins
- game_over  in  1  one-cycle pulse: run ended
- digits  out  4 x NUM_DIGITS  displayed score BCD; index 0 is the most significant digit
- hi_digits  out  4 x NUM_DIGITS  high score BCD; index 0 is the most significant digit
- paint  out  1  score digits visible
- new_high  out  1  last game_over set a new high score

Behaviour:
- Reset values: score 0, accumulator 0, hi 0, state IDLE, flash timer 0, flash iteration 0, paint 1, new_high 0. Therefore digits and hi_digits read all zero.
- Priority per cycle, highest first: rst, restart, game_over, halt (speed==0), update.
- Accumulator:
  - Width is $clog2(COEFFICIENT + 2**SPEED_W).
  - On update with speed != 0: if acc + speed >= COEFFICIENT, then acc <= acc + speed - COEFFICIENT and the score increments; otherwise acc <= acc + speed.
  - At most one increment per tick.
- BCD increment:
  - Ripple carry; each digit wraps 9 to 0 and carries into the next digit.
  - If the score is all-9s, it holds and the accumulator still updates.
  - Increment result is visible the cycle after update.
- Achievement detect:
  - Fires when an increment (not blocked by saturation) leaves the low ACH_DIGITS digits all zero and the score is non-zero.
  - On fire: latch the new score into ach_score, state <= FLASH_OFF, timer <= 0, iteration <= 0.
  - A new achievement during a flash restarts the flash with the new value.
- Flash FSM, advancing only on update ticks:
  - IDLE: paint = 1; digits show the live score.
  - FLASH_OFF: paint = 0; digits show ach_score. Timer counts on update; at timer == FLASH_DURATION-1, go to FLASH_ON with timer 0.
  - FLASH_ON: paint = 1; digits show ach_score. At timer == FLASH_DURATION-1, timer 0. If iteration == FLASH_ITERATIONS-1, go to IDLE; otherwise iteration++ and go to FLASH_OFF.
  - paint is registered and changes in the same cycle as the state.
- Halt (speed == 0, any cycle):
  - FSM goes to IDLE and paint <= 1.
  - Score, acc and hi hold; update is ignored.
- game_over:
  - If score > hi (BCD compare, MSD first): hi <= score and new_high <= 1.
  - Otherwise hi holds and new_high <= 0.
  - Also forces IDLE and paint 1.
  - Score is frozen until restart.
- restart:
  - Score, acc, ach_score, timer and iteration go to 0; state IDLE; paint 1; new_high 0.
  - hi is preserved.
- game_over and restart in the same cycle: restart wins; hi is not updated.
- Mid-operation rst: identical to power-on reset, including clearing hi.

Decomposition:
- Package score_meter_pkg:
  - bcd_t (logic [3:0]).
  - Flash state enum {IDLE, FLASH_OFF, FLASH_ON}.
  - Default parameter constants.
  - Function bcd_gt(a, b) for the MSD-first compare.
- Sub-module bcd_counter:
  - Parameter NUM_DIGITS.
  - Ports: clk, rst, clr, inc, value, saturated, wrapped_low[NUM_DIGITS] (per-digit "this digit and all below just wrapped to zero").
- Top-level: accumulator, flash FSM, high-score logic.

Test Plan:
Benches override COEFFICIENT=100, FLASH_DURATION=2, FLASH_ITERATIONS=2, NUM_DIGITS=3, ACH_DIGITS=1.
- Accumulation: speed=30, 10 update ticks -> score 003, acc 0; increments occur after ticks 4, 7 and 10.
- Achievement at 10: preload score 009, speed=99, one tick -> digits 010 (live). paint follows 0,0,1,1,0,0,1,1 over the next 8 ticks, then IDLE. digits stay 010 throughout, even after the score advances to 011.
- Saturation: score 999, speed=99, 5 ticks -> digits stay 999, no flash triggered, acc keeps updating.
- Halt mid-flash: enter FLASH_OFF, drive speed=0 for one cycle -> paint 1 the next cycle, state IDLE, score unchanged.
- High score: run to 042 then game_over -> hi 042, new_high 1. restart -> score 000, hi 042, new_high 0. Run to 017 then game_over -> hi 042, new_high 0.
- Collisions: restart and game_over in the same cycle at score 050 -> score 000, hi unchanged. rst mid-flash -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/score_meter_pkg.sv
// Shared types and defaults for the score meter: BCD digit type, flash states,
// default parameters and an MSD-first BCD magnitude compare.
package score_meter_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE,
    FLASH_OFF,
    FLASH_ON
  } flash_state_e;

  localparam int DEF_NUM_DIGITS       = 5;
  localparam int DEF_SPEED_W          = 15;
  localparam int DEF_COEFFICIENT      = 40960;
  localparam int DEF_ACH_DIGITS       = 2;
  localparam int DEF_FLASH_DURATION   = 15;
  localparam int DEF_FLASH_ITERATIONS = 3;

  // Widest score the compare helper handles; callers zero-extend into it.
  localparam int BCD_MAX_DIGITS = 16;

  typedef logic [BCD_MAX_DIGITS-1:0][3:0] bcd_wide_t;

  // Element 0 is the least significant digit; the first differing digit from
  // the top decides.
  function automatic logic bcd_gt(input bcd_wide_t a, input bcd_wide_t b);
    logic gt;
    logic done;
    gt   = 1'b0;
    done = 1'b0;
    for (int i = BCD_MAX_DIGITS - 1; i >= 0; i--) begin
      if (!done && (a[i] != b[i])) begin
        gt   = (a[i] > b[i]);
        done = 1'b1;
      end
    end
    return gt;
  endfunction

endpackage

// File: rtl/score_meter_bcd_counter.sv
// Saturating ripple-carry BCD up-counter. value[0] is the least significant
// digit; wrapped_low[i] flags that digits 0..i roll to zero on this increment.
module bcd_counter
  import score_meter_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       inc,
  output logic [NUM_DIGITS-1:0][3:0] value,
  output logic                       saturated,
  output logic                       wrapped_low [NUM_DIGITS]
);

  logic [NUM_DIGITS-1:0][3:0] value_nxt;

  always_comb begin
    saturated = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (value[i] != 4'd9) saturated = 1'b0;
    end
  end

  // Carry enters at the bottom and ripples while digits sit at 9.
  always_comb begin
    logic carry;
    carry     = inc && !saturated;
    value_nxt = value;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      wrapped_low[i] = carry && (value[i] == 4'd9);
      if (carry) value_nxt[i] = (value[i] == 4'd9) ? 4'd0 : value[i] + 4'd1;
      carry = wrapped_low[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) value <= '0;
    else            value <= value_nxt;
  end

endmodule

// File: rtl/score_meter.sv
// Frame-tick score meter: speed accumulator feeding a saturating BCD score,
// achievement flash FSM and high-score tracking for the sprite renderer.
module score_meter
  import score_meter_pkg::*;
#(
  parameter int NUM_DIGITS       = DEF_NUM_DIGITS,
  parameter int SPEED_W          = DEF_SPEED_W,
  parameter int COEFFICIENT      = DEF_COEFFICIENT,
  parameter int ACH_DIGITS       = DEF_ACH_DIGITS,
  parameter int FLASH_DURATION   = DEF_FLASH_DURATION,
  parameter int FLASH_ITERATIONS = DEF_FLASH_ITERATIONS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               update,
  input  logic [SPEED_W-1:0] speed,
  input  logic               restart,
  input  logic               game_over,
  output bcd_t               digits    [NUM_DIGITS],
  output bcd_t               hi_digits [NUM_DIGITS],
  output logic               paint,
  output logic               new_high
);

  localparam int AW = $clog2(COEFFICIENT + 2**SPEED_W);
  localparam int TW = $clog2(FLASH_DURATION + 1);
  localparam int IW = $clog2(FLASH_ITERATIONS + 1);

  logic [AW-1:0]              acc, acc_sum;
  logic [NUM_DIGITS-1:0][3:0] score, hi, ach_score, shown;
  logic                       saturated;
  logic                       wrapped_low [NUM_DIGITS];
  logic                       frozen, ach_load, beat_hi;
  logic                       halt, upd_en, inc, ach_fire;
  flash_state_e               state, state_nxt;
  logic [TW-1:0]              timer, timer_nxt;
  logic [IW-1:0]              iter, iter_nxt;
  bcd_wide_t                  score_ext, hi_ext;

  assign halt     = (speed == '0);
  assign upd_en   = update && !halt && !restart && !game_over && !frozen;
  assign acc_sum  = acc + AW'(speed);
  assign inc      = upd_en && (acc_sum >= AW'(COEFFICIENT));
  // Low digits wrapping without saturation always leaves a non-zero score.
  assign ach_fire = inc && !saturated && wrapped_low[ACH_DIGITS-1];

  bcd_counter #(.NUM_DIGITS(NUM_DIGITS)) u_score (
    .clk        (clk),
    .rst        (rst),
    .clr        (restart),
    .inc        (inc),
    .value      (score),
    .saturated  (saturated),
    .wrapped_low(wrapped_low)
  );

  always_ff @(posedge clk) begin
    if (rst || restart) acc <= '0;
    else if (upd_en)    acc <= inc ? acc_sum - AW'(COEFFICIENT) : acc_sum;
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    iter_nxt  = iter;
    if (restart || game_over || halt) begin
      state_nxt = IDLE;
      timer_nxt = '0;
      iter_nxt  = '0;
    end else if (ach_fire) begin
      state_nxt = FLASH_OFF;
      timer_nxt = '0;
      iter_nxt  = '0;
    end else if (upd_en) begin
      case (state)
        FLASH_OFF: begin
          if (timer == TW'(FLASH_DURATION - 1)) begin
            state_nxt = FLASH_ON;
            timer_nxt = '0;
          end else timer_nxt = timer + TW'(1);
        end
        FLASH_ON: begin
          if (timer == TW'(FLASH_DURATION - 1)) begin
            timer_nxt = '0;
            if (iter == IW'(FLASH_ITERATIONS - 1)) state_nxt = IDLE;
            else begin
              iter_nxt  = iter + IW'(1);
              state_nxt = FLASH_OFF;
            end
          end else timer_nxt = timer + TW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      iter  <= '0;
      paint <= 1'b1;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      iter  <= iter_nxt;
      paint <= (state_nxt != FLASH_OFF);
    end
  end

  always_comb begin
    score_ext = '0;
    hi_ext    = '0;
    score_ext[NUM_DIGITS-1:0] = score;
    hi_ext[NUM_DIGITS-1:0]    = hi;
    beat_hi = bcd_gt(score_ext, hi_ext);
  end

  // The achieved value is captured from the counter one cycle after the
  // increment; until then the live score already equals it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi        <= '0;
      new_high  <= 1'b0;
      frozen    <= 1'b0;
      ach_score <= '0;
      ach_load  <= 1'b0;
    end else if (restart) begin
      new_high  <= 1'b0;
      frozen    <= 1'b0;
      ach_score <= '0;
      ach_load  <= 1'b0;
    end else begin
      ach_load <= ach_fire;
      if (ach_load) ach_score <= score;
      if (game_over) begin
        frozen   <= 1'b1;
        new_high <= beat_hi;
        if (beat_hi) hi <= score;
      end
    end
  end

  assign shown = ((state == IDLE) || ach_load) ? score : ach_score;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_out
    assign digits[i]    = shown[NUM_DIGITS-1-i];
    assign hi_digits[i] = hi[NUM_DIGITS-1-i];
  end

endmodule

// File: tb/tb_score_meter.sv
// Scoreboard bench for score_meter: a behavioural model pushes expected
// outputs per driven cycle; scenario tasks pop and compare after the edge.
module tb_score_meter;

  localparam int ND = 3, SW = 15, C = 100, ACH = 1, FD = 2, FI = 2;
  localparam int MAXS = 999, ACH_MOD = 10;

  logic          clk = 1'b0, rst = 1'b1, update = 1'b0, restart = 1'b0, game_over = 1'b0;
  logic [SW-1:0] speed = '0;
  logic [3:0]    digits    [ND];
  logic [3:0]    hi_digits [ND];
  logic          paint, new_high;

  score_meter #(
    .NUM_DIGITS(ND), .SPEED_W(SW), .COEFFICIENT(C), .ACH_DIGITS(ACH),
    .FLASH_DURATION(FD), .FLASH_ITERATIONS(FI)
  ) dut (
    .clk(clk), .rst(rst), .update(update), .speed(speed), .restart(restart),
    .game_over(game_over), .digits(digits), .hi_digits(hi_digits),
    .paint(paint), .new_high(new_high)
  );

  always #5 clk = ~clk;

  typedef struct { int digits; int hi; bit paint; bit nh; } exp_t;
  exp_t sb_q [$];
  int checks = 0, failures = 0;

  int m_score, m_acc, m_hi, m_ach, m_timer, m_iter, m_st;
  bit m_paint, m_nh, m_frozen;

  function automatic int bcd_val(input logic [3:0] d [ND]);
    int v = 0;
    for (int i = 0; i < ND; i++) v = v * 10 + int'(d[i]);
    return v;
  endfunction

  task automatic model_step(input bit upd, input int spd, input bit rs, input bit go, input bit r);
    bit fire;
    if (r) begin
      m_score = 0; m_acc = 0; m_hi = 0; m_ach = 0; m_timer = 0; m_iter = 0;
      m_st = 0; m_paint = 1; m_nh = 0; m_frozen = 0;
    end else if (rs) begin
      m_score = 0; m_acc = 0; m_ach = 0; m_timer = 0; m_iter = 0;
      m_st = 0; m_paint = 1; m_nh = 0; m_frozen = 0;
    end else if (go) begin
      if (m_score > m_hi) begin m_hi = m_score; m_nh = 1; end
      else m_nh = 0;
      m_st = 0; m_paint = 1; m_frozen = 1; m_timer = 0; m_iter = 0;
    end else if (spd == 0) begin
      m_st = 0; m_paint = 1; m_timer = 0; m_iter = 0;
    end else if (upd && !m_frozen) begin
      fire = 0;
      if (m_acc + spd >= C) begin
        m_acc = m_acc + spd - C;
        if (m_score < MAXS) begin
          m_score++;
          fire = (m_score % ACH_MOD) == 0;
        end
      end else m_acc += spd;
      if (fire) begin
        m_ach = m_score; m_st = 1; m_timer = 0; m_iter = 0;
      end else if (m_st == 1) begin
        if (m_timer == FD - 1) begin m_st = 2; m_timer = 0; end
        else m_timer++;
      end else if (m_st == 2) begin
        if (m_timer == FD - 1) begin
          m_timer = 0;
          if (m_iter == FI - 1) m_st = 0;
          else begin m_iter++; m_st = 1; end
        end else m_timer++;
      end
      m_paint = (m_st != 1);
    end
  endtask

  task automatic drive(input bit upd, input int spd, input bit rs, input bit go, input bit r);
    exp_t e;
    update = upd; speed = SW'(spd); restart = rs; game_over = go; rst = r;
    model_step(upd, spd, rs, go, r);
    e.digits = (m_st == 0) ? m_score : m_ach;
    e.hi = m_hi; e.paint = m_paint; e.nh = m_nh;
    sb_q.push_back(e);
    @(posedge clk); #1;
    update = 0; restart = 0; game_over = 0; rst = 0;
  endtask

  task automatic ramp_to(input int target, input int limit, input string tag);
    exp_t e;
    for (int i = 0; i < limit && m_score != target; i++) begin
      drive(1, 99, 0, 0, 0);
      e = sb_q.pop_front();
      checks++;
      if (bcd_val(digits) !== e.digits || paint !== e.paint) begin
        failures++;
        $display("FAIL %s_ramp tick=%0d digits=%0d paint=%b expected digits=%0d paint=%b",
                 tag, i, bcd_val(digits), paint, e.digits, e.paint);
      end
    end
    checks++;
    if (m_score != target) begin
      failures++;
      $display("FAIL %s_ramp_budget score=%0d expected=%0d", tag, m_score, target);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    drive(0, 0, 0, 0, 1);
    e = sb_q.pop_front();
    checks++;
    if (bcd_val(digits) !== 0 || bcd_val(hi_digits) !== e.hi || paint !== 1'b1 || new_high !== 1'b0) begin
      failures++;
      $display("FAIL reset digits=%0d hi=%0d paint=%b new_high=%b expected 0 0 1 0",
               bcd_val(digits), bcd_val(hi_digits), paint, new_high);
    end
  endtask

  task automatic test_accumulation();
    exp_t e;
    drive(0, 30, 1, 0, 0);
    e = sb_q.pop_front();
    for (int t = 1; t <= 10; t++) begin
      drive(1, 30, 0, 0, 0);
      e = sb_q.pop_front();
      checks++;
      if (bcd_val(digits) !== e.digits || paint !== e.paint) begin
        failures++;
        $display("FAIL accum tick=%0d digits=%0d paint=%b expected digits=%0d paint=%b",
                 t, bcd_val(digits), paint, e.digits, e.paint);
      end
    end
    checks++;
    if (bcd_val(digits) !== 3 || int'(dut.acc) !== 0) begin
      failures++;
      $display("FAIL accum_final digits=%0d acc=%0d expected digits=3 acc=0", bcd_val(digits), dut.acc);
    end
  endtask

  task automatic test_achievement();
    exp_t e;
    drive(0, 99, 1, 0, 0);
    e = sb_q.pop_front();
    ramp_to(9, 20, "ach");
    drive(1, 99, 0, 0, 0);
    e = sb_q.pop_front();
    checks++;
    if (bcd_val(digits) !== 10 || paint !== 1'b0) begin
      failures++;
      $display("FAIL ach_fire digits=%0d paint=%b expected digits=10 paint=0", bcd_val(digits), paint);
    end
    for (int t = 1; t <= 8; t++) begin
      drive(1, 99, 0, 0, 0);
      e = sb_q.pop_front();
      checks++;
      if (bcd_val(digits) !== e.digits || paint !== e.paint) begin
        failures++;
        $display("FAIL ach_flash tick=%0d digits=%0d paint=%b expected digits=%0d paint=%b",
                 t, bcd_val(digits), paint, e.digits, e.paint);
      end
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    drive(0, 99, 1, 0, 0);
    e = sb_q.pop_front();
    ramp_to(MAXS, 1100, "sat");
    for (int t = 1; t <= 5; t++) begin
      drive(1, 99, 0, 0, 0);
      e = sb_q.pop_front();
      checks++;
      if (bcd_val(digits) !== 999 || paint !== 1'b1 || int'(dut.acc) !== m_acc) begin
        failures++;
        $display("FAIL sat tick=%0d digits=%0d paint=%b acc=%0d expected digits=999 paint=1 acc=%0d",
                 t, bcd_val(digits), paint, dut.acc, m_acc);
      end
    end
  endtask

  task automatic test_halt();
    exp_t e;
    int held;
    drive(0, 99, 1, 0, 0);
    e = sb_q.pop_front();
    ramp_to(10, 20, "halt");
    checks++;
    if (paint !== 1'b0) begin
      failures++;
      $display("FAIL halt_pre paint=%b expected 0", paint);
    end
    held = m_score;
    for (int t = 1; t <= 2; t++) begin
      drive(1, 0, 0, 0, 0);
      e = sb_q.pop_front();
      checks++;
      if (paint !== 1'b1 || bcd_val(digits) !== held || e.digits !== held || int'(dut.state) !== 0) begin
        failures++;
        $display("FAIL halt tick=%0d digits=%0d paint=%b state=%0d expected digits=%0d paint=1 state=0",
                 t, bcd_val(digits), paint, dut.state, held);
      end
    end
  endtask

  task automatic test_high_score();
    exp_t e;
    drive(0, 99, 1, 0, 0);
    e = sb_q.pop_front();
    ramp_to(42, 60, "hi1");
    drive(0, 99, 0, 1, 0);
    e = sb_q.pop_front();
    checks++;
    if (bcd_val(hi_digits) !== 42 || new_high !== 1'b1 || bcd_val(digits) !== e.digits) begin
      failures++;
      $display("FAIL hi_set hi=%0d new_high=%b digits=%0d expected hi=42 new_high=1 digits=%0d",
               bcd_val(hi_digits), new_high, bcd_val(digits), e.digits);
    end
    for (int t = 1; t <= 3; t++) begin
      drive(1, 99, 0, 0, 0);
      e = sb_q.pop_front();
      checks++;
      if (bcd_val(digits) !== 42 || e.digits !== 42) begin
        failures++;
        $display("FAIL frozen tick=%0d digits=%0d expected 42", t, bcd_val(digits));
      end
    end
    drive(0, 99, 1, 0, 0);
    e = sb_q.pop_front();
    checks++;
    if (bcd_val(digits) !== 0 || bcd_val(hi_digits) !== 42 || new_high !== 1'b0) begin
      failures++;
      $display("FAIL hi_restart digits=%0d hi=%0d new_high=%b expected 0 42 0",
               bcd_val(digits), bcd_val(hi_digits), new_high);
    end
    ramp_to(17, 30, "hi2");
    drive(0, 99, 0, 1, 0);
    e = sb_q.pop_front();
    checks++;
    if (bcd_val(hi_digits) !== 42 || new_high !== 1'b0 || e.hi !== 42) begin
      failures++;
      $display("FAIL hi_keep hi=%0d new_high=%b expected hi=42 new_high=0", bcd_val(hi_digits), new_high);
    end
  endtask

  task automatic test_collisions();
    exp_t e;
    drive(0, 99, 1, 0, 0);
    e = sb_q.pop_front();
    ramp_to(50, 70, "coll");
    drive(0, 99, 1, 1, 0);
    e = sb_q.pop_front();
    checks++;
    if (bcd_val(digits) !== 0 || bcd_val(hi_digits) !== 42 || new_high !== 1'b0 || e.hi !== 42) begin
      failures++;
      $display("FAIL restart_go digits=%0d hi=%0d new_high=%b expected 0 42 0",
               bcd_val(digits), bcd_val(hi_digits), new_high);
    end
    ramp_to(10, 20, "rstflash");
    drive(1, 99, 0, 0, 1);
    e = sb_q.pop_front();
    checks++;
    if (bcd_val(digits) !== 0 || bcd_val(hi_digits) !== 0 || paint !== 1'b1 || new_high !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_flash digits=%0d hi=%0d paint=%b new_high=%b expected 0 0 1 0",
               bcd_val(digits), bcd_val(hi_digits), paint, new_high);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_accumulation();
    test_achievement();
    test_saturation();
    test_halt();
    test_high_score();
    test_collisions();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
